// File: rtl/scope_capture_pkg.sv
// Shared types and helpers for the scope capture RAM.
//   state_t  : capture FSM encoding (IDLE, ARMED, POST, DONE)
//   ptr_next : circular pointer increment modulo an arbitrary depth
package scope_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    DONE
  } state_t;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/scope_capture_dpram.sv
// Inferred simple dual-port RAM: one write port, one read port with a
// registered output. A read colliding with a write returns the old word.
//   we/waddr/wdata : write port
//   re/raddr       : read enable and address; rdata updates the cycle after re
//   rdata          : holds its value while re is low
module scope_capture_dpram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 40096
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_capture_ram.sv
// Scope sample RAM with streaming capture side and Avalon-MM CPU slave.
// Capture: arm starts a circular capture; a trigger is qualified only once
// enough pre-trigger samples are stored; P samples follow the trigger.
//   clk, reset_n                 : clock, async active-low reset
//   s_valid, s_data, trig_in     : ADC sample stream and trigger qualifier
//   arm, post_count              : start pulse and post-trigger length
//   busy, done, trig_addr        : capture status
//   address, chipselect, read,
//   write, writedata, readdata   : Avalon-MM slave, 1-cycle read latency
// Optional macro SCOPE_CAPTURE_DECIM_EN adds input decim[7:0] (keep every
// (decim+1)-th valid sample).
module scope_capture_ram
  import scope_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 40096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              trig_in,
  input  logic              arm,
  input  logic [ADDR_W-1:0] post_count,
`ifdef SCOPE_CAPTURE_DECIM_EN
  input  logic [7:0]        decim,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata
);

  localparam logic [ADDR_W:0]   DEPTH_F = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] post_left;
  logic [ADDR_W-1:0] p_lat;
  logic [ADDR_W:0]   fill;
  logic [ADDR_W:0]   trig_need;
  logic              capturing;
  logic              dec_ok;
  logic              cap_ok;
  logic              in_range;
  logic              cpu_we;
  logic              rd_zero;
  logic [DATA_W-1:0] ram_q;

`ifdef SCOPE_CAPTURE_DECIM_EN
  logic [7:0] dec_lat;
  logic [7:0] dec_cnt;

  // Phase counter runs on every valid sample while capturing; only phase 0
  // is accepted, so the first valid after arm is always kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_lat <= '0;
      dec_cnt <= '0;
    end else if (arm) begin
      dec_lat <= decim;
      dec_cnt <= '0;
    end else if (capturing && s_valid) begin
      dec_cnt <= (dec_cnt == dec_lat) ? '0 : dec_cnt + 8'd1;
    end
  end

  assign dec_ok = (dec_cnt == '0);
`else
  assign dec_ok = 1'b1;
`endif

  assign capturing = (state == ARMED) || (state == POST);
  assign cap_ok    = capturing && s_valid && !arm && dec_ok;
  assign trig_need = {1'b0, LAST_A} - {1'b0, p_lat};
  assign in_range  = ({1'b0, address} < DEPTH_F);
  assign cpu_we    = chipselect && write && !busy && in_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      post_left <= '0;
      p_lat     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      trig_addr <= '0;
    end else if (arm) begin
      state  <= ARMED;
      wr_ptr <= '0;
      fill   <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
      p_lat  <= (post_count > LAST_A) ? LAST_A : post_count;
    end else if (cap_ok) begin
      wr_ptr <= ADDR_W'(ptr_next(32'(wr_ptr), DEPTH));
      if (fill != DEPTH_F) fill <= fill + 1'b1;
      case (state)
        ARMED: begin
          // fill counts samples stored before this one
          if (trig_in && (fill >= trig_need)) begin
            trig_addr <= wr_ptr;
            if (p_lat == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= POST;
              post_left <= p_lat;
            end
          end
        end
        POST: begin
          post_left <= post_left - 1'b1;
          if (post_left == ADDR_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Out-of-range reads skip the RAM and force zero on the registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                rd_zero <= 1'b1;
    else if (chipselect && read) rd_zero <= !in_range;
  end

  assign readdata = rd_zero ? '0 : ram_q;

  scope_capture_dpram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (cap_ok || cpu_we),
    .waddr(cap_ok ? wr_ptr : address),
    .wdata(cap_ok ? s_data : writedata),
    .re   (chipselect && read && in_range),
    .raddr(address),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_scope_capture_ram.sv
module tb_scope_capture_ram;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              trig_in;
  logic              arm;
  logic [ADDR_W-1:0] post_count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
`ifdef SCOPE_CAPTURE_DECIM_EN
  logic [7:0]        decim;
`endif

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  scope_capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .trig_in   (trig_in),
    .arm       (arm),
    .post_count(post_count),
`ifdef SCOPE_CAPTURE_DECIM_EN
    .decim     (decim),
`endif
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr),
    .address   (address),
    .chipselect(chipselect),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic do_arm(input logic [ADDR_W-1:0] pc);
    arm = 1'b1;
    post_count = pc;
    tick();
    arm = 1'b0;
  endtask

  task automatic sample(input logic [DATA_W-1:0] d, input logic t);
    s_valid = 1'b1;
    s_data  = d;
    trig_in = t;
    tick();
    s_valid = 1'b0;
    trig_in = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    address = a;
    chipselect = 1'b1;
    read = 1'b1;
    tick();
    chipselect = 1'b0;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write = 1'b1;
    tick();
    chipselect = 1'b0;
    write = 1'b0;
  endtask

  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] exp_ram [DEPTH];

  initial begin
    reset_n = 1'b1; s_valid = 1'b0; s_data = '0; trig_in = 1'b0;
    arm = 1'b0; post_count = '0; address = '0; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; writedata = '0;
`ifdef SCOPE_CAPTURE_DECIM_EN
    decim = '0;
`endif
    #2;
    do_reset();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    chk("rst_readdata", 32'(readdata), 0);

    // Test 1: post 3, trigger on sample 8
    do_arm(16'd3);
    chk("t1_busy_armed", 32'(busy), 1);
    for (int i = 1; i <= 20; i++) begin
      sample(8'(i), i == 8);
      if (i == 10) chk("t1_done_s10", 32'(done), 0);
      if (i == 11) begin
        chk("t1_done_s11", 32'(done), 1);
        chk("t1_busy_s11", 32'(busy), 0);
      end
    end
    chk("t1_trig_addr", 32'(trig_addr), 7);
    exp_ram = '{8'd11, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    for (int a = 0; a < 10; a++) begin
      cpu_read(16'(a), rd);
      chk($sformatf("t1_ram%0d", a), 32'(rd), 32'(exp_ram[a]));
    end

    // Test 2: early trigger on 3 ignored, trigger on 9 accepted
    do_arm(16'd3);
    for (int i = 1; i <= 14; i++) begin
      sample(8'(i), (i == 3) || (i == 9));
      if (i == 3) chk("t2_busy_s3", 32'(busy), 1);
      if (i == 11) chk("t2_done_s11", 32'(done), 0);
      if (i == 12) chk("t2_done_s12", 32'(done), 1);
    end
    chk("t2_trig_addr", 32'(trig_addr), 8);
    cpu_read(16'd1, rd);
    chk("t2_ram1", 32'(rd), 12);
    cpu_read(16'd2, rd);
    chk("t2_ram2", 32'(rd), 3);

    // Test 3: post 0, trigger at wr_ptr 9
    do_arm(16'd0);
    for (int i = 1; i <= 12; i++) begin
      sample(8'(i), i == 10);
      if (i == 9) chk("t3_done_s9", 32'(done), 0);
      if (i == 10) chk("t3_done_s10", 32'(done), 1);
    end
    chk("t3_trig_addr", 32'(trig_addr), 9);
    cpu_read(16'd0, rd);
    chk("t3_no_wrap_write", 32'(rd), 1);

    // Test 4: re-arm mid-POST with s_valid high
    do_arm(16'd3);
    for (int i = 1; i <= 8; i++) sample(8'(i), i == 8);
    chk("t4_busy_post", 32'(busy), 1);
    arm = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    tick();
    arm = 1'b0; s_valid = 1'b0;
    chk("t4_busy_rearm", 32'(busy), 1);
    chk("t4_done_rearm", 32'(done), 0);
    sample(8'h33, 1'b0);
    cpu_read(16'd0, rd);
    chk("t4_ptr_zero", 32'(rd), 32'h33);
    cpu_read(16'd8, rd);
    chk("t4_discarded", 32'(rd), 9);
    cpu_read(16'd1, rd);
    chk("t4_ram1", 32'(rd), 2);

    // Test 5: CPU access, collision, out of range
    do_reset();
    chk("t5_rst_busy", 32'(busy), 0);
    cpu_write(16'd4, 8'hA5);
    cpu_write(16'd0, 8'h3C);
    cpu_read(16'd4, rd);
    chk("t5_rd4", 32'(rd), 32'hA5);
    tick(); tick();
    chk("t5_hold", 32'(readdata), 32'hA5);
    do_arm(16'd3);
    // capture write and CPU read of address 0 in the same cycle
    s_valid = 1'b1; s_data = 8'hC3;
    address = 16'd0; chipselect = 1'b1; read = 1'b1;
    tick();
    s_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    chk("t5_collision_old", 32'(readdata), 32'h3C);
    cpu_read(16'd0, rd);
    chk("t5_after_collision", 32'(rd), 32'hC3);
    cpu_write(16'd4, 8'h5A);
    cpu_read(16'd4, rd);
    chk("t5_busy_write_ignored", 32'(rd), 32'hA5);
    cpu_read(16'd12, rd);
    chk("t5_oob_read", 32'(rd), 0);

`ifdef SCOPE_CAPTURE_DECIM_EN
    // Decimation by 3
    do_reset();
    decim = 8'd2;
    do_arm(16'd3);
    decim = 8'd0;
    for (int i = 1; i <= 9; i++) sample(8'(i), 1'b0);
    cpu_read(16'd0, rd);
    chk("dec_ram0", 32'(rd), 1);
    cpu_read(16'd1, rd);
    chk("dec_ram1", 32'(rd), 4);
    cpu_read(16'd2, rd);
    chk("dec_ram2", 32'(rd), 7);
    // wr_ptr now at 3: next kept sample lands there
    sample(8'hE1, 1'b0);
    cpu_read(16'd3, rd);
    chk("dec_ram3", 32'(rd), 32'hE1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
